// File: rtl/stream_mem_loader.sv
// Stream-to-memory bus master: turns header/address/payload command words into
// picorv32-style native bus reads and writes. Define LOADER_ACK_EN to emit a completion ack word.
`timescale 1ns/1ps

module stream_mem_loader #(
    parameter int MEM_BYTES = 131072,
    parameter int MAX_LEN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        val_in,
    output logic        ready_upward,
    output logic [31:0] dout,
    output logic        val_out,
    input  logic        ready_downward,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [31:0]          ADDR_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;
    localparam logic [MAX_LEN_W-1:0] LEN_ZERO  = {MAX_LEN_W{1'b0}};
    localparam logic [MAX_LEN_W-1:0] LEN_ONE   = MAX_LEN_W'(1'b1);

    typedef enum logic [2:0] {
        S_HDR     = 3'd0,
        S_ADDR    = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_BUS  = 3'd3,
        S_RD_BUS  = 3'd4,
        S_RD_OUT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               state_r;
    logic                 op_r;
    logic [MAX_LEN_W-1:0] len_r;
    logic [MAX_LEN_W-1:0] cnt_r;
    logic [31:0]          addr_r;
    logic [31:0]          wdata_r;
    logic [3:0]           wstrb_r;
    logic                 mem_valid_r;
    logic                 ready_upward_r;
    logic [31:0]          dout_r;
    logic                 val_out_r;
    logic                 busy_r;

    logic                 in_xfer_s;
    logic                 out_xfer_s;
    logic                 bus_done_s;
    logic                 last_s;
    logic [31:0]          next_addr_s;

    assign in_xfer_s   = val_in & ready_upward_r;
    assign out_xfer_s  = val_out_r & ready_downward;
    assign bus_done_s  = mem_valid_r & mem_ready;
    assign last_s      = (cnt_r == LEN_ONE);
    assign next_addr_s = (addr_r + 32'd4) & ADDR_MASK;

`ifdef LOADER_ACK_EN
    logic [15:0] len16_s;
    logic [31:0] ack_word_s;

    if (MAX_LEN_W >= 16) begin : g_len_trunc
        assign len16_s = len_r[15:0];
    end else begin : g_len_pad
        assign len16_s = {{(16 - MAX_LEN_W){1'b0}}, len_r};
    end

    assign ack_word_s = 32'hACC0_0000 | {op_r, 15'd0, len16_s};
`endif

    // Command FSM; ready/busy are registered alongside each state change so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_HDR;
            op_r           <= 1'b0;
            len_r          <= LEN_ZERO;
            cnt_r          <= LEN_ZERO;
            addr_r         <= 32'd0;
            wdata_r        <= 32'd0;
            wstrb_r        <= 4'h0;
            mem_valid_r    <= 1'b0;
            ready_upward_r <= 1'b0;
            dout_r         <= 32'd0;
            val_out_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                S_HDR: begin
                    ready_upward_r <= 1'b1;
                    if (in_xfer_s) begin
                        op_r    <= din[31];
                        len_r   <= din[MAX_LEN_W-1:0];
                        busy_r  <= 1'b1;
                        state_r <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (in_xfer_s) begin
                        addr_r <= din & ADDR_MASK;
                        cnt_r  <= len_r;
                        if (len_r == LEN_ZERO) begin
                            ready_upward_r <= 1'b0;
                            state_r        <= S_DONE;
                        end else if (!op_r) begin
                            state_r <= S_WR_DATA;
                        end else begin
                            ready_upward_r <= 1'b0;
                            mem_valid_r    <= 1'b1;
                            wstrb_r        <= 4'h0;
                            state_r        <= S_RD_BUS;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (in_xfer_s) begin
                        wdata_r        <= din;
                        wstrb_r        <= 4'hF;
                        mem_valid_r    <= 1'b1;
                        ready_upward_r <= 1'b0;
                        state_r        <= S_WR_BUS;
                    end
                end
                S_WR_BUS: begin
                    if (bus_done_s) begin
                        mem_valid_r <= 1'b0;
                        wstrb_r     <= 4'h0;
                        addr_r      <= next_addr_s;
                        cnt_r       <= cnt_r - LEN_ONE;
                        if (last_s) begin
                            state_r <= S_DONE;
                        end else begin
                            ready_upward_r <= 1'b1;
                            state_r        <= S_WR_DATA;
                        end
                    end
                end
                S_RD_BUS: begin
                    if (bus_done_s) begin
                        dout_r      <= mem_rdata;
                        val_out_r   <= 1'b1;
                        mem_valid_r <= 1'b0;
                        addr_r      <= next_addr_s;
                        state_r     <= S_RD_OUT;
                    end
                end
                S_RD_OUT: begin
                    if (out_xfer_s) begin
                        val_out_r <= 1'b0;
                        cnt_r     <= cnt_r - LEN_ONE;
                        if (last_s) begin
                            state_r <= S_DONE;
                        end else begin
                            mem_valid_r <= 1'b1;
                            state_r     <= S_RD_BUS;
                        end
                    end
                end
                S_DONE: begin
`ifdef LOADER_ACK_EN
                    // First DONE cycle launches the ack; leave once downstream takes it.
                    if (!val_out_r) begin
                        dout_r    <= ack_word_s;
                        val_out_r <= 1'b1;
                    end else if (ready_downward) begin
                        val_out_r      <= 1'b0;
                        ready_upward_r <= 1'b1;
                        busy_r         <= 1'b0;
                        state_r        <= S_HDR;
                    end
`else
                    ready_upward_r <= 1'b1;
                    busy_r         <= 1'b0;
                    state_r        <= S_HDR;
`endif
                end
                default: begin
                    state_r        <= S_HDR;
                    mem_valid_r    <= 1'b0;
                    ready_upward_r <= 1'b0;
                    val_out_r      <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign ready_upward = ready_upward_r;
    assign dout         = dout_r;
    assign val_out      = val_out_r;
    assign mem_valid    = mem_valid_r;
    assign mem_instr    = 1'b0;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign mem_wstrb    = wstrb_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_stream_mem_loader.sv
// Self-checking bench for stream_mem_loader: directed plus randomized commands
// against a memory responder and an address-arithmetic reference model.
`timescale 1ns/1ps

module tb_stream_mem_loader;

    localparam int MEM_BYTES = 131072;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        val_in;
    logic        ready_upward;
    logic [31:0] dout;
    logic        val_out;
    logic        ready_downward;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;

    stream_mem_loader #(.MEM_BYTES(MEM_BYTES), .MAX_LEN_W(16)) dut (
        .clk(clk), .reset(reset), .din(din), .val_in(val_in), .ready_upward(ready_upward),
        .dout(dout), .val_out(val_out), .ready_downward(ready_downward),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } txn_t;

    int          tests = 0;
    int          fails = 0;
    int          delay = 0;
    int          req_cnt = 0;
    txn_t        log_q[$];
    logic [31:0] resp_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: answers valid & !ready after 'delay' extra cycles and watches request stability.
    int          wait_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] cap_a, cap_d;
    logic [3:0]  cap_s;
    always @(negedge clk) begin
        if (prev_ready) chk("valid_after_ready", mem_valid, 1'b0);
        if (mem_valid && !prev_valid) begin
            req_cnt++;
            cap_a = mem_addr; cap_d = mem_wdata; cap_s = mem_wstrb;
        end else if (mem_valid && prev_valid) begin
            chk("hold_addr", mem_addr, cap_a);
            chk("hold_wdata", mem_wdata, cap_d);
            chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, cap_s});
        end
        prev_valid = mem_valid;
        if (mem_valid && !mem_ready) begin
            if (wait_cnt >= delay) begin
                txn_t t;
                mem_ready = 1'b1;
                if (mem_wstrb == 4'hF) resp_mem[mem_addr] = mem_wdata;
                mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : 32'd0;
                t.a = mem_addr; t.d = (mem_wstrb == 4'hF) ? mem_wdata : mem_rdata; t.s = mem_wstrb;
                log_q.push_back(t);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        prev_ready = mem_ready;
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        din = w; val_in = 1'b1;
        while (!ready_upward && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        val_in = 1'b0;
    endtask

    task automatic recv(input logic [31:0] exp, input int stall, input string tag);
        int n = 0;
        logic [31:0] cap;
        while (!val_out && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, {31'd0, val_out}, 32'd1);
        chk(tag, dout, exp);
        cap = dout;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, {31'd0, val_out}, 32'd1);
            chk({tag, "_hold_d"}, dout, cap);
        end
        ready_downward = 1'b1;
        @(negedge clk);
        ready_downward = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    // One full command; expectations come from modular address arithmetic and ref_mem.
    task automatic do_cmd(input logic op, input int len, input logic [31:0] aw, input int stall);
        logic [31:0] base, a;
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        int r0;
        base = aw & 32'(MEM_BYTES - 4);
        log_q.delete();
        r0 = req_cnt;
        send({op, 15'd0, 16'(len)});
        send(aw);
        for (int i = 0; i < len; i++) begin
            a = 32'((64'(base) + 64'(4 * i)) % 64'(MEM_BYTES));
            exp_a.push_back(a);
            if (!op) begin
                send(wq[i]);
                ref_mem[a] = wq[i];
                exp_d.push_back(wq[i]);
            end else begin
                exp_d.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'd0);
                recv(exp_d[i], stall, "rd_data");
            end
        end
`ifdef LOADER_ACK_EN
        recv(32'hACC0_0000 | {op, 15'd0, 16'(len)}, 0, "ack");
`endif
        wait_idle();
        chk("n_txn", 32'(log_q.size()), 32'(len));
        chk("n_req", 32'(req_cnt - r0), 32'(len));
        for (int i = 0; i < len && i < log_q.size(); i++) begin
            chk("bus_addr", log_q[i].a, exp_a[i]);
            chk("bus_data", log_q[i].d, exp_d[i]);
            chk("bus_strb", {28'd0, log_q[i].s}, op ? 32'd0 : 32'hF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] aw;
        int r0;
        reset = 1'b1; din = 32'd0; val_in = 1'b0; ready_downward = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready_up", {31'd0, ready_upward}, 32'd0);
        chk("rst_val_out", {31'd0, val_out}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("mem_instr", {31'd0, mem_instr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        wq = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_cmd(1'b0, 3, 32'h0000_0100, 0);
        do_cmd(1'b1, 2, 32'h0000_0104, 5);

        delay = 7;
        wq = '{32'hDEADBEEF};
        do_cmd(1'b0, 1, 32'h0000_0200, 0);
        delay = 0;

        wq = '{32'hA5A5_0001, 32'h5A5A_0002};
        do_cmd(1'b0, 2, 32'h0001_FFFC, 0);
        do_cmd(1'b1, 2, 32'hFFFF_FFFF, 1);

        do_cmd(1'b0, 0, 32'h0000_0040, 0);
        do_cmd(1'b1, 0, 32'h0000_0040, 0);

        delay = 20;
        log_q.delete();
        r0 = req_cnt;
        send(32'h0000_0001);
        send(32'h0000_0300);
        send(32'hBADC_0FFE);
        chk("wr_bus_entered", {31'd0, mem_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("abort_ready_up", {31'd0, ready_upward}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        delay = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_txn", 32'(log_q.size()), 32'd0);
        chk("abort_one_req", 32'(req_cnt - r0), 32'd1);
        wq = '{32'h5A5A_5A5A};
        do_cmd(1'b0, 1, 32'h0000_0300, 0);
        do_cmd(1'b1, 1, 32'h0000_0300, 0);

        for (int c = 0; c < 16; c++) begin
            logic op;
            int len;
            op    = 1'($urandom_range(0, 1));
            len   = $urandom_range(0, 4);
            aw    = $urandom;
            delay = $urandom_range(0, 3);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back($urandom);
            do_cmd(op, len, aw, $urandom_range(0, 2));
            if (!op && len > 0) do_cmd(1'b1, len, aw, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
